mips_instr_encoder: RTL and testbench
=====================================

// Module: mips_instr_encoder
// PURPOSE
// Inverse of the opcode control decoder: packs field-level MIPS instruction descriptors
// (opcode/rs/rt/rd/shamt/funct/imm/target) into 32-bit words and streams them into
// instruction memory at consecutive word addresses. Used by the test/boot loader path
// to fill IMEM before the core leaves reset. Only opcodes the control decoder supports are encoded.
// PARAMETERS
// ADDR_W  8    instruction-memory word-address width
// DEPTH   256  words available in IMEM; must be <= 2**ADDR_W
// PORTS
// clk         in   1       clock, rising edge
// rst_n       in   1       async active-low reset
// start       in   1       begin new load; ignored unless busy=0
// in_valid    in   1       descriptor valid
// in_ready    out  1       descriptor accepted when in_valid&in_ready
// in_opcode   in   6       opcode field
// in_rs/in_rt/in_rd/in_shamt in 5 each  register/shift fields
// in_funct    in   6       R-type function
// in_imm      in   16      I-type immediate
// in_target   in   26      J-type target
// in_last     in   1       final descriptor of the load
// mem_we      out  1       IMEM write strobe
// mem_addr    out  ADDR_W  IMEM word address
// mem_wdata   out  32      encoded instruction
// busy        out  1       load in progress
// done        out  1       1-cycle pulse at end of load
// err_op      out  1       sticky: unsupported opcode seen; cleared by start
// err_full    out  1       sticky: DEPTH reached before in_last; cleared by start
// err_opcode  out  6       first unsupported opcode captured
// word_count  out  ADDR_W+1 words written this load
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, address counter 0; mem_we drops immediately (async).
// - FSM IDLE -> LOAD on start (clears counter/errors). LOAD -> FLUSH on accepted in_last or when
//   word_count reaches DEPTH. FLUSH -> DONE after final write cycle -> IDLE; done=1 in DONE.
// - in_ready = (state==LOAD) && (word_count < DEPTH). Throughput 1 word/cycle.
// - Latency: descriptor accepted in cycle N -> mem_we/mem_addr/mem_wdata registered, valid in N+1.
// - Encoding: RTYPE {op,rs,rt,rd,shamt,funct}; LW/SW/BEQ/BNE/ADDI/ANDI/ORI/XORI {op,rs,rt,imm};
//   LUI {op,5'b0,rt,imm} (rs forced 0); J/JAL {op,target}. Unused input fields ignored.
// - Unsupported opcode: descriptor consumed, no write, counter unchanged; err_op set, err_opcode
//   captured only if err_op was 0. If it carries in_last, the load still terminates normally.
// - Full: word DEPTH-1 written without in_last -> in_ready low, err_full=1, terminate via FLUSH/DONE.
// - mem_addr = word_count before increment; counter never wraps.
// - start while busy ignored; in_valid outside LOAD ignored (in_ready=0).
// STRUCTURE
// - Opcodes from existing `MIPS_* macros in defines.vh; add FMT_R/FMT_I/FMT_J format constants.
// - One combinational sub-module mips_instr_pack: fields + opcode -> {word, supported}.
// - Top holds FSM, address counter, output registers, error flags.
// TESTING
// - start; ADDI rs=1 rt=2 imm=0x0005 last=1 -> next cycle mem_we=1 addr=0 wdata=0x20220005; done pulse.
// - R-type rs=1 rt=2 rd=3 funct=0x20, then JAL target=0x0000100 back-to-back -> 0x00221820@0, 0x0C000100@1.
// - LUI rs=7 rt=1 imm=0x1234 -> wdata=0x3C011234 (rs zeroed).
// - opcode 0x3F between two ADDIs -> 2 writes at addr 0,1; err_op=1, err_opcode=0x3F, word_count=2.
// - DEPTH=4, 5 descriptors no last -> writes at 0..3, 5th not accepted, err_full=1, done pulse.
// - rst_n low mid-stream -> mem_we=0 same cycle, busy=0; new start writes from addr 0.

Source files
------------

// File: rtl/mips_instr_encoder_pkg.sv
// mips_instr_encoder_pkg
// Shared definitions for the IMEM loader encoder:
//   - MIPS_* opcode constants for every opcode the control decoder supports
//   - instruction format classification (FMT_R / FMT_I / FMT_J / FMT_NONE)
//   - opFormat(): opcode -> format. FMT_NONE marks an unsupported opcode.
//   - loader FSM state constants
package mips_instr_encoder_pkg;

  localparam logic [5:0] MIPS_RTYPE = 6'h00;
  localparam logic [5:0] MIPS_J     = 6'h02;
  localparam logic [5:0] MIPS_JAL   = 6'h03;
  localparam logic [5:0] MIPS_BEQ   = 6'h04;
  localparam logic [5:0] MIPS_BNE   = 6'h05;
  localparam logic [5:0] MIPS_ADDI  = 6'h08;
  localparam logic [5:0] MIPS_ANDI  = 6'h0C;
  localparam logic [5:0] MIPS_ORI   = 6'h0D;
  localparam logic [5:0] MIPS_XORI  = 6'h0E;
  localparam logic [5:0] MIPS_LUI   = 6'h0F;
  localparam logic [5:0] MIPS_LW    = 6'h23;
  localparam logic [5:0] MIPS_SW    = 6'h2B;

  typedef enum logic [1:0] {
    FMT_NONE = 2'd0,
    FMT_R    = 2'd1,
    FMT_I    = 2'd2,
    FMT_J    = 2'd3
  } fmt_t;

  // Loader FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic fmt_t opFormat(input logic [5:0] opcode);
    fmt_t fmt;
    case (opcode)
      MIPS_RTYPE:                         fmt = FMT_R;
      MIPS_J, MIPS_JAL:                   fmt = FMT_J;
      MIPS_BEQ, MIPS_BNE, MIPS_ADDI,
      MIPS_ANDI, MIPS_ORI, MIPS_XORI,
      MIPS_LUI, MIPS_LW, MIPS_SW:         fmt = FMT_I;
      default:                            fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/mips_instr_encoder_pack.sv
// mips_instr_pack
// Purely combinational field packer: one instruction descriptor -> one 32-bit word.
// Ports:
//   opcode/rs/rt/rd/shamt/funct/imm/target  in   descriptor fields
//   word                                    out  encoded instruction (0 when unsupported)
//   supported                               out  1 if opcode is one the decoder understands
module mips_instr_pack
  import mips_instr_encoder_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        supported
);

  logic [4:0] rsField;

  // LUI has no source register; whatever the caller put in rs is dropped
  assign rsField = (opcode == MIPS_LUI) ? 5'd0 : rs;

  always_comb begin
    word      = '0;
    supported = 1'b0;
    case (opFormat(opcode))
      FMT_R: begin
        word      = {opcode, rs, rt, rd, shamt, funct};
        supported = 1'b1;
      end
      FMT_I: begin
        word      = {opcode, rsField, rt, imm};
        supported = 1'b1;
      end
      FMT_J: begin
        word      = {opcode, target};
        supported = 1'b1;
      end
      default: begin
        word      = '0;
        supported = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
// Streams encoded MIPS instructions into IMEM at consecutive word addresses.
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   start                       begin a new load (only honoured when idle)
//   in_valid/in_ready           descriptor handshake, 1 descriptor per cycle
//   in_opcode..in_target        descriptor fields; in_last marks the final one
//   mem_we/mem_addr/mem_wdata   registered IMEM write port
//   busy/done                   load in progress / 1-cycle end-of-load pulse
//   err_op/err_opcode           sticky unsupported-opcode flag + first offender
//   err_full                    sticky: IMEM filled before in_last
//   word_count                  words written in the current/last load
module mips_instr_encoder
  import mips_instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_op,
  output logic              err_full,
  output logic [5:0]        err_opcode,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] depthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] lastIdx  = depthCnt - 1'b1;

  logic [1:0]  stateReg;
  logic [1:0]  stateNext;
  logic [31:0] packWord;
  logic        packOk;
  logic        accept;
  logic        writeOk;
  logic        fillsMem;

  mips_instr_pack uPack (
    .opcode    (in_opcode),
    .rs        (in_rs),
    .rt        (in_rt),
    .rd        (in_rd),
    .shamt     (in_shamt),
    .funct     (in_funct),
    .imm       (in_imm),
    .target    (in_target),
    .word      (packWord),
    .supported (packOk)
  );

  assign in_ready = (stateReg == ST_LOAD) && (word_count < depthCnt);
  assign accept   = in_valid && in_ready;
  // Unsupported descriptors are consumed but never written
  assign writeOk  = accept && packOk;
  // This write occupies the final IMEM word; nothing more can be accepted
  assign fillsMem = writeOk && (word_count == lastIdx);

  assign busy = (stateReg != ST_IDLE);
  assign done = (stateReg == ST_DONE);

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      ST_IDLE:  if (start) stateNext = ST_LOAD;
      ST_LOAD:  if ((accept && in_last) || fillsMem) stateNext = ST_FLUSH;
      ST_FLUSH: stateNext = ST_DONE;   // final write is on the port this cycle
      ST_DONE:  stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg   <= ST_IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err_op     <= 1'b0;
      err_full   <= 1'b0;
      err_opcode <= '0;
      word_count <= '0;
    end else begin
      stateReg <= stateNext;
      mem_we   <= writeOk;

      if (stateReg == ST_IDLE && start) begin
        word_count <= '0;
        err_op     <= 1'b0;
        err_full   <= 1'b0;
        err_opcode <= '0;
      end

      if (writeOk) begin
        mem_addr   <= word_count[ADDR_W-1:0];
        mem_wdata  <= packWord;
        word_count <= word_count + 1'b1;
      end

      // Only the first unsupported opcode of a load is kept
      if (accept && !packOk && !err_op) begin
        err_op     <= 1'b1;
        err_opcode <= in_opcode;
      end

      if (fillsMem && !in_last) err_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
module tb_mips_instr_encoder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    bit          last;
  } desc_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    desc_t       d;
    bit          expOk;
    logic [31:0] expWord;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [5:0]  in_opcode = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [5:0]  in_funct = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic in_last = 1'b0;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic busy, done, err_op, err_full;
  logic [5:0] err_opcode;
  logic [ADDR_W:0] word_count;

  always #5 clk = ~clk;

  mips_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err_op(err_op), .err_full(err_full), .err_opcode(err_opcode), .word_count(word_count)
  );

  int nCompared = 0;
  int nMismatched = 0;
  int doneCnt = 0;
  int accepted = 0;
  int loadId = 0;
  wr_t writeQ[$];
  desc_t loadQ[$];

  // Observe IMEM writes and done pulses away from the active edge
  always @(negedge clk) begin
    if (mem_we) writeQ.push_back('{mem_addr, mem_wdata});
    if (done) doneCnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoding written from the instruction-format rules
  function automatic bit refEncode(input desc_t d, output logic [31:0] w);
    logic [31:0] op, rs, rt, rd, sh, fn, im, tg;
    op = 32'(d.op);  rs = 32'(d.rs); rt = 32'(d.rt); rd = 32'(d.rd);
    sh = 32'(d.shamt); fn = 32'(d.funct); im = 32'(d.imm); tg = 32'(d.target);
    w = 32'h0;
    case (d.op)
      6'h00: w = (op << 26) | (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | fn;
      6'h02, 6'h03: w = (op << 26) | tg;
      6'h0F: w = (op << 26) | (rt << 16) | im;
      6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B:
        w = (op << 26) | (rs << 21) | (rt << 16) | im;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic desc_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                               input logic [25:0] tg, input bit last);
    desc_t d;
    d.op = op; d.rs = rs; d.rt = rt; d.rd = rd; d.shamt = 5'd0; d.funct = fn;
    d.imm = imm; d.target = tg; d.last = last;
    return d;
  endfunction

  // Issue start, then feed loadQ until it is exhausted, in_last is taken or in_ready drops
  task automatic runLoad(input bit gaps);
    int c;
    writeQ.delete();
    doneCnt = 0;
    accepted = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    foreach (loadQ[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_opcode = loadQ[i].op; in_rs = loadQ[i].rs; in_rt = loadQ[i].rt; in_rd = loadQ[i].rd;
      in_shamt = loadQ[i].shamt; in_funct = loadQ[i].funct; in_imm = loadQ[i].imm;
      in_target = loadQ[i].target; in_last = loadQ[i].last;
      in_valid = 1'b1;
      if (!in_ready) break;
      @(negedge clk);
      accepted++;
      if (loadQ[i].last) break;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    c = 0;
    while (busy && c < 30) begin
      @(negedge clk);
      c++;
    end
    check("load_terminates", 64'(busy), 64'(0));
  endtask

  // Model the whole load from the descriptor list and compare against observations
  task automatic checkLoad();
    wr_t expQ[$];
    int cnt = 0, acc = 0;
    bit eop = 0, efull = 0;
    logic [5:0] eopc = '0;
    logic [31:0] w;
    foreach (loadQ[i]) begin
      if (cnt >= DEPTH) break;
      acc++;
      if (refEncode(loadQ[i], w)) begin
        expQ.push_back('{ADDR_W'(cnt), w});
        cnt++;
      end else if (!eop) begin
        eop = 1;
        eopc = loadQ[i].op;
      end
      if (loadQ[i].last) break;
      if (cnt == DEPTH) begin
        efull = 1;
        break;
      end
    end
    check("write_count", 64'(writeQ.size()), 64'(expQ.size()));
    foreach (expQ[i]) begin
      if (i < writeQ.size()) begin
        check($sformatf("addr[%0d]", i), 64'(writeQ[i].addr), 64'(expQ[i].addr));
        check($sformatf("wdata[%0d]", i), 64'(writeQ[i].data), 64'(expQ[i].data));
      end
    end
    check("accepted", 64'(accepted), 64'(acc));
    check("err_op", 64'(err_op), 64'(eop));
    check("err_opcode", 64'(err_opcode), 64'(eopc));
    check("err_full", 64'(err_full), 64'(efull));
    check("word_count", 64'(word_count), 64'(cnt));
    check("done_pulses", 64'(doneCnt), 64'(1));
    $display("load %0d: %0d descriptors, %0d accepted, %0d writes, err_op=%0d err_full=%0d",
             loadId, loadQ.size(), accepted, writeQ.size(), err_op, err_full);
    loadId++;
  endtask

  vec_t vecs[$];
  logic [5:0] supOps[12] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                             6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

  initial begin
    // Reset state
    #2;
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_errs", 64'({err_op, err_full, err_opcode}), 64'(0));
    check("rst_word_count", 64'(word_count), 64'(0));
    check("rst_mem_port", 64'({mem_addr, mem_wdata}), 64'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Single-descriptor loads with hand-encoded expectations
    vecs.push_back('{mk(6'h08, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0005, 26'h0, 1), 1, 32'h20220005});
    vecs.push_back('{mk(6'h0F, 5'd7, 5'd1, 5'd0, 6'h00, 16'h1234, 26'h0, 1), 1, 32'h3C011234});
    vecs.push_back('{mk(6'h2B, 5'd29, 5'd31, 5'd0, 6'h00, 16'hFFFC, 26'h0, 1), 1, 32'hAFBFFFFC});
    vecs.push_back('{mk(6'h04, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0003, 26'h0, 1), 1, 32'h10220003});
    vecs.push_back('{mk(6'h02, 5'd9, 5'd9, 5'd9, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1), 1, 32'h0BFFFFFF});
    vecs.push_back('{mk(6'h00, 5'd1, 5'd2, 5'd3, 6'h20, 16'hFFFF, 26'h0, 1), 1, 32'h00221820});
    vecs.push_back('{mk(6'h3F, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0001, 26'h0, 1), 0, 32'h0});
    for (int i = 0; i < vecs.size(); i++) begin
      loadQ.delete();
      loadQ.push_back(vecs[i].d);
      runLoad(0);
      check($sformatf("vec%0d_writes", i), 64'(writeQ.size()), 64'(vecs[i].expOk ? 1 : 0));
      if (vecs[i].expOk && writeQ.size() > 0) begin
        check($sformatf("vec%0d_addr", i), 64'(writeQ[0].addr), 64'(0));
        check($sformatf("vec%0d_wdata", i), 64'(writeQ[0].data), 64'(vecs[i].expWord));
      end
      if (!vecs[i].expOk) begin
        check($sformatf("vec%0d_err_op", i), 64'(err_op), 64'(1));
        check($sformatf("vec%0d_err_opcode", i), 64'(err_opcode), 64'(vecs[i].d.op));
      end
      check($sformatf("vec%0d_done", i), 64'(doneCnt), 64'(1));
      $display("vector %0d: op=0x%02h writes=%0d", i, vecs[i].d.op, writeQ.size());
    end

    // R-type then JAL back-to-back
    loadQ.delete();
    loadQ.push_back(mk(6'h00, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 0));
    loadQ.push_back(mk(6'h03, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h0000100, 1));
    runLoad(0);
    checkLoad();
    if (writeQ.size() == 2) check("jal_word", 64'(writeQ[1].data), 64'h0C000100);

    // Unsupported opcode between two ADDIs
    loadQ.delete();
    loadQ.push_back(mk(6'h08, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0005, 26'h0, 0));
    loadQ.push_back(mk(6'h3F, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0005, 26'h0, 0));
    loadQ.push_back(mk(6'h08, 5'd3, 5'd4, 5'd0, 6'h00, 16'h0006, 26'h0, 1));
    runLoad(0);
    checkLoad();
    check("badop_word_count", 64'(word_count), 64'(2));
    check("badop_opcode", 64'(err_opcode), 64'h3F);

    // Fill IMEM without in_last: five offered, four taken
    loadQ.delete();
    for (int i = 0; i < 5; i++)
      loadQ.push_back(mk(6'h08, 5'd1, 5'd2, 5'd0, 6'h00, 16'(i), 26'h0, 0));
    runLoad(0);
    checkLoad();
    check("full_flag", 64'(err_full), 64'(1));
    check("full_accepted", 64'(accepted), 64'(4));

    // Async reset while writes are in flight
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    in_opcode = 6'h08; in_rs = 5'd1; in_rt = 5'd2; in_imm = 16'h0011; in_last = 1'b0;
    in_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    check("pre_reset_mem_we", 64'(mem_we), 64'(1));
    rst_n = 1'b0;
    #1;
    check("reset_mem_we", 64'(mem_we), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    loadQ.delete();
    loadQ.push_back(mk(6'h0D, 5'd5, 5'd6, 5'd0, 6'h00, 16'hBEEF, 26'h0, 1));
    runLoad(0);
    checkLoad();

    // Start while busy must be ignored: a second start mid-load leaves counter alone
    loadQ.delete();
    loadQ.push_back(mk(6'h08, 5'd1, 5'd1, 5'd0, 6'h00, 16'h1, 26'h0, 0));
    loadQ.push_back(mk(6'h08, 5'd1, 5'd1, 5'd0, 6'h00, 16'h2, 26'h0, 1));
    fork
      runLoad(0);
      begin
        @(negedge clk); @(negedge clk); @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    checkLoad();

    // Randomized loads against the reference model
    for (int n = 0; n < 40; n++) begin
      int len;
      loadQ.delete();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        desc_t d;
        d.op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : supOps[$urandom_range(0, 11)];
        d.rs = 5'($urandom); d.rt = 5'($urandom); d.rd = 5'($urandom);
        d.shamt = 5'($urandom); d.funct = 6'($urandom);
        d.imm = 16'($urandom); d.target = 26'($urandom);
        d.last = (i == len - 1);
        loadQ.push_back(d);
      end
      runLoad(1);
      checkLoad();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
